// File: rtl/pipe_ctrl_pkg.sv
//------------------------------------------------------------------------------
// pipe_ctrl_pkg: state encodings, shadow limits and control bundle for pipe_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [1:0] PC_RUN    = 2'd0;
  localparam logic [1:0] PC_SHADOW = 2'd1;
  localparam logic [1:0] PC_HALT   = 2'd2;

  localparam int FLUSH_SHADOW_MAX = 3;
  localparam int SHADOW_W         = 2;

  typedef struct packed {
    logic pc_en;
    logic pc_load;
    logic ifid_en;
    logic idex_en;
    logic exma_en;
    logic mamo_en;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_satcnt.sv
//------------------------------------------------------------------------------
// pipe_ctrl_satcnt: CNT_W-bit up counter that sticks at all-ones
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_satcnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// pipe_ctrl: pipeline enable/flush/bubble/PC controller for IF/ID/EX/MA/MO.
// Optional perf counters under macro PIPE_CTRL_PERF_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_SHADOW = 1,
  parameter int CNT_W        = 32
) (
  input  logic             iw_clk,
  input  logic             iw_rst_n,
  input  logic             iw_stall_req,
  input  logic             iw_flush_req,
  input  logic             iw_mem_busy,
  input  logic             iw_halt,
  input  logic             iw_resume,
  output logic             ow_pc_en,
  output logic             ow_pc_load,
  output logic             ow_ifid_en,
  output logic             ow_idex_en,
  output logic             ow_exma_en,
  output logic             ow_mamo_en,
  output logic             ow_ifid_flush,
  output logic             ow_idex_bubble,
  output logic             ow_halted,
  output logic [CNT_W-1:0] ow_stall_cnt,
  output logic [CNT_W-1:0] ow_flush_cnt
);

  localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(FLUSH_SHADOW);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [SHADOW_W-1:0] shadow_cnt;
  logic [SHADOW_W-1:0] shadow_nxt;
  logic                flush_pend;
  logic                pend_nxt;
  logic                stall_go;
  ctrl_t               ctrl;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state      <= PC_RUN;
      shadow_cnt <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_nxt;
      flush_pend <= pend_nxt;
    end
  end

  // Priority chain: halted state, halt, mem_busy, flush (live or pending), shadow, stall, normal.
  always_comb begin
    ctrl       = '0;
    state_nxt  = state;
    shadow_nxt = shadow_cnt;
    pend_nxt   = flush_pend;
    stall_go   = 1'b0;
    if (state == PC_HALT) begin
      pend_nxt = 1'b0;
      if (iw_resume && !iw_halt) begin
        state_nxt = PC_RUN;
      end
    end else if (iw_halt) begin
      ctrl.mamo_en = 1'b1;
      state_nxt    = PC_HALT;
      shadow_nxt   = '0;
      pend_nxt     = 1'b0;
    end else if (iw_mem_busy) begin
      pend_nxt = flush_pend | iw_flush_req;
    end else if (iw_flush_req || flush_pend) begin
      ctrl     = '1;
      pend_nxt = 1'b0;
      if (FLUSH_SHADOW > 0) begin
        state_nxt  = PC_SHADOW;
        shadow_nxt = SHADOW_LOAD;
      end else begin
        state_nxt  = PC_RUN;
        shadow_nxt = '0;
      end
    end else if (state == PC_SHADOW) begin
      ctrl             = '1;
      ctrl.pc_load     = 1'b0;
      ctrl.idex_bubble = 1'b0;
      shadow_nxt       = shadow_cnt - SHADOW_W'(1);
      if (shadow_cnt <= SHADOW_W'(1)) begin
        state_nxt  = PC_RUN;
        shadow_nxt = '0;
      end
    end else if (iw_stall_req) begin
      stall_go         = 1'b1;
      ctrl.idex_en     = 1'b1;
      ctrl.exma_en     = 1'b1;
      ctrl.mamo_en     = 1'b1;
      ctrl.idex_bubble = 1'b1;
    end else begin
      ctrl.pc_en   = 1'b1;
      ctrl.ifid_en = 1'b1;
      ctrl.idex_en = 1'b1;
      ctrl.exma_en = 1'b1;
      ctrl.mamo_en = 1'b1;
    end
  end

  // Reset forces every control low even though the outputs are combinational.
  assign ow_pc_en       = iw_rst_n & ctrl.pc_en;
  assign ow_pc_load     = iw_rst_n & ctrl.pc_load;
  assign ow_ifid_en     = iw_rst_n & ctrl.ifid_en;
  assign ow_idex_en     = iw_rst_n & ctrl.idex_en;
  assign ow_exma_en     = iw_rst_n & ctrl.exma_en;
  assign ow_mamo_en     = iw_rst_n & ctrl.mamo_en;
  assign ow_ifid_flush  = iw_rst_n & ctrl.ifid_flush;
  assign ow_idex_bubble = iw_rst_n & ctrl.idex_bubble;
  assign ow_halted      = iw_rst_n & (state == PC_HALT);

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_satcnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (iw_clk),
    .rst_n (iw_rst_n),
    .inc   (stall_go),
    .cnt   (ow_stall_cnt)
  );

  pipe_ctrl_satcnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (iw_clk),
    .rst_n (iw_rst_n),
    .inc   (ctrl.pc_load),
    .cnt   (ow_flush_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf  = stall_go;
  assign ow_stall_cnt = '0;
  assign ow_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline-control responder. It consumes the stall request from the hazard detector and redirect, memory-wait and halt events from later stages. From these it drives per-stage advance enables, bubble/flush controls and PC update for the five-stage IF/ID/EX/MA/MO pipeline. It is the single owner of pipeline-register enables; no stage gates its own register.

Parameters:
FLUSH_SHADOW, 1, extra cycles after a redirect during which IF/ID stays flushed (fetch latency shadow), 0..3
CNT_W, 32, width of performance counters (used only with PIPE_CTRL_PERF_EN)

Ports:
iw_clk  in  1  clock, rising edge
iw_rst_n  in  1  asynchronous active-low reset
iw_stall_req  in  1  load-use stall request from hazard unit, combinational, same cycle
iw_flush_req  in  1  taken branch/jump resolved in EX, 1-cycle pulse
iw_mem_busy  in  1  data memory not ready; freezes whole pipe
iw_halt  in  1  HLT reached MO stage
iw_resume  in  1  debug resume from halt
ow_pc_en  out  1  PC register advances
ow_pc_load  out  1  PC takes redirect target this cycle
ow_ifid_en  out  1  IF/ID register enable
ow_idex_en  out  1  ID/EX register enable
ow_exma_en  out  1  EX/MA register enable
ow_mamo_en  out  1  MA/MO register enable
ow_ifid_flush  out  1  IF/ID loads NOP
ow_idex_bubble  out  1  ID/EX loads NOP (stall bubble or flush)
ow_halted  out  1  core halted
ow_stall_cnt  out  CNT_W  stall cycles (PIPE_CTRL_PERF_EN only)
ow_flush_cnt  out  CNT_W  redirects (PIPE_CTRL_PERF_EN only)

Behaviour:
- States: RUN, SHADOW, HALT. Reset state: RUN, shadow counter 0, flush-pending 0, counters 0.
- While iw_rst_n low, all enables, pc_en, pc_load, flush and bubble are 0, and ow_halted is 0.
- Outputs are combinational from the registered state plus the current inputs. There is no added latency on the stall response.
- Priority per cycle: halt > mem_busy > flush > stall > normal.
- RUN, normal: all enables 1, pc_en 1, flush and bubble 0.
- RUN + stall_req: pc_en 0, ifid_en 0, idex_en 1 with idex_bubble 1, exma_en and mamo_en 1. A multi-cycle stall simply repeats this each cycle the request is high.
- RUN + flush_req: pc_load 1, pc_en 1, ifid_flush 1, idex_bubble 1, all enables 1. Any stall_req in the same cycle is ignored, because the stalled instruction is killed.
- After a flush: if FLUSH_SHADOW > 0, go to SHADOW with counter = FLUSH_SHADOW; otherwise stay in RUN.
- SHADOW: ifid_flush 1 and pc_en 1; stall_req is ignored. Counter decrements each cycle; at 1 go to RUN. A new flush_req in SHADOW reloads the counter and asserts pc_load.
- mem_busy: all enables 0, pc_en 0, flush and bubble 0, and the shadow counter is held.
- flush_req during mem_busy: latched into flush-pending and applied on the first non-busy cycle as a normal flush. A pending flush plus a new flush_req collapses to one redirect.
- halt (any state): enter HALT in the next state. In the halt cycle itself, mamo_en is 1 and all other enables are 0, so HLT retires.
- HALT: all enables 0, ow_halted 1, and flush-pending is cleared. iw_resume goes to RUN the next cycle. halt and resume in the same cycle means halt wins.
- Reset mid-SHADOW or mid-HALT returns to RUN immediately and asynchronously.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: ow_stall_cnt increments on each RUN cycle where a stall is applied (not masked by flush, busy or halt). ow_flush_cnt increments on each applied pc_load. Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and the counter logic is absent.

Decomposition:
- Shared header alongside sizes.vh: state encodings PC_RUN=2'd0, PC_SHADOW=2'd1, PC_HALT=2'd2, and the FLUSH_SHADOW maximum.
- One natural sub-module, pipe_ctrl_satcnt: a saturating CNT_W-bit counter with an increment input, instantiated twice under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset: hold iw_rst_n low 3 cycles while driving flush_req=1 -> all outputs 0; after release with no requests -> all enables 1, pc_en 1.
- Stall: stall_req high for 2 cycles -> pc_en 0, ifid_en 0 and idex_bubble 1 for exactly 2 cycles; exma_en and mamo_en stay 1; stall_cnt=2.
- Flush and stall together, FLUSH_SHADOW=1: flush_req and stall_req high in cycle N -> pc_load 1, ifid_flush 1 and idex_bubble 1 in N; ifid_flush 1 in N+1; RUN in N+2; stall_cnt unchanged, flush_cnt=1.
- Busy with flush: mem_busy high for cycles N..N+2, flush_req pulse at N+1 -> all enables 0 during N..N+2; pc_load 1 in N+3 only.
- Halt: halt at N with stall_req high -> mamo_en 1 and others 0 in N; ow_halted 1 from N+1; resume at N+5 -> ow_halted 0 and enables 1 at N+6.
- Saturation (CNT_W=4): hold stall_req 20 cycles -> stall_cnt=15 and holds.
